// File: rtl/transform_in.sv
// Row-beat to tile assembler with two ping-pong tile buffers.
// Full tiles are presented in fill order, transposed on the way out when requested.
module transform_in #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COLS*DW-1:0]       in_data,
  input  logic                     in_last,
  input  logic                     in_trans,
  output logic                     tile_valid,
  input  logic                     tile_ready,
  output logic [ROWS*COLS*DW-1:0]  tile_data,
  output logic [1:0]               occ,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW = COLS * DW;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [BW-1:0] mem_q [2][ROWS];
  logic [1:0]    full_q, full_d;
  logic [1:0]    trans_q, trans_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic          err_q, err_d;
  logic          accept, drain, last_row;

  assign in_ready   = !full_q[wr_sel_q];
  assign tile_valid = full_q[rd_sel_q];
  assign occ        = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign err        = err_q;

  always_comb begin
    accept   = in_valid && in_ready;
    drain    = tile_valid && tile_ready;
    last_row = (wr_row_q == LAST_ROW);
    full_d   = full_q;
    trans_d  = trans_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_row_d = wr_row_q;
    err_d    = err_q;
    if (accept) begin
      if (wr_row_q == '0) trans_d[wr_sel_q] = in_trans;
      if (last_row) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        wr_row_d         = '0;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
    // Fill and drain never address the same buffer, so both updates can apply.
    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    if (accept && (in_last != last_row)) err_d = 1'b1;
    else if (err_clr)                    err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      trans_q  <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_row_q <= '0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      trans_q  <= trans_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_row_q <= wr_row_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned r = 0; r < ROWS; r++)
          mem_q[b][r] <= '0;
    end else if (accept) begin
      mem_q[wr_sel_q][wr_row_q] <= in_data;
    end
  end

  // Transpose is only meaningful for square tiles; otherwise rows pass straight through.
  if (ROWS == COLS) begin : g_square
    always_comb begin
      tile_data = '0;
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          if (trans_q[rd_sel_q])
            tile_data[(r*COLS+c)*DW +: DW] = mem_q[rd_sel_q][c][r*DW +: DW];
          else
            tile_data[(r*COLS+c)*DW +: DW] = mem_q[rd_sel_q][r][c*DW +: DW];
    end
  end else begin : g_rect
    always_comb begin
      tile_data = '0;
      for (int unsigned r = 0; r < ROWS; r++)
        tile_data[r*BW +: BW] = mem_q[rd_sel_q][r];
    end
  end

endmodule

// File: tb/tb_transform_in.sv
// Randomized bench for transform_in against a queue-of-tiles reference model.
module tb_transform_in;
  localparam int R = 8;
  localparam int C = 8;
  localparam int W = 32;

  typedef logic [R-1:0][C-1:0][W-1:0] tile_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [C*W-1:0]   in_data = '0;
  logic             in_last = 1'b0;
  logic             in_trans = 1'b0;
  logic             tile_valid;
  logic             tile_ready = 1'b0;
  logic [R*C*W-1:0] tile_data;
  logic [1:0]       occ;
  logic             err;
  logic             err_clr = 1'b0;

  transform_in #(.ROWS(R), .COLS(C), .DW(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_trans(in_trans),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .occ(occ), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: completed tiles waiting in order, plus the tile being filled.
  tile_t done_q[$];
  bit    done_t[$];
  tile_t part;
  bit    part_t;
  int    row;
  bit    m_err;

  function automatic tile_t view(input tile_t t, input bit tr);
    tile_t v;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        v[r][c] = tr ? t[c][r] : t[r][c];
    return v;
  endfunction

  task automatic model_reset();
    done_q.delete();
    done_t.delete();
    part   = '0;
    part_t = 1'b0;
    row    = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs();
    tile_t e;
    check("in_ready", in_ready, done_q.size() < 2);
    check("tile_valid", tile_valid, done_q.size() > 0);
    check("occ", occ, done_q.size());
    check("err", err, m_err);
    if (done_q.size() > 0) begin
      e = view(done_q[0], done_t[0]);
      for (int r = 0; r < R; r++)
        check($sformatf("tile_row%0d", r), tile_data[r*C*W +: C*W], e[r]);
    end
  endtask

  task automatic check_zero_tile();
    for (int r = 0; r < R; r++)
      check($sformatf("rst_tile_row%0d", r), tile_data[r*C*W +: C*W], '0);
  endtask

  // One clock: drive at negedge, compare, then advance the model past the posedge.
  task automatic step(input int pv, input int pr, input int perr, input bit pat);
    bit acc, drn;
    @(negedge clk);
    in_valid   = ($urandom_range(99) < pv);
    tile_ready = ($urandom_range(99) < pr);
    for (int c = 0; c < C; c++)
      in_data[c*W +: W] = pat ? W'(row*C + c) : $urandom;
    in_trans = $urandom_range(1);
    in_last  = (row == R-1);
    if ($urandom_range(99) < perr) in_last = !in_last;
    err_clr  = ($urandom_range(15) == 0);
    #1;
    check_outputs();
    acc = in_valid && (done_q.size() < 2);
    drn = tile_ready && (done_q.size() > 0);
    if (acc && (in_last != (row == R-1))) m_err = 1'b1;
    else if (err_clr)                     m_err = 1'b0;
    if (drn) begin
      void'(done_q.pop_front());
      void'(done_t.pop_front());
    end
    if (acc) begin
      if (row == 0) part_t = in_trans;
      part[row] = in_data;
      if (row == R-1) begin
        done_q.push_back(part);
        done_t.push_back(part_t);
        row = 0;
      end else begin
        row++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_zero_tile();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    model_reset();
    check_outputs();
    check_zero_tile();
    @(negedge clk);
    rst = 1'b0;

    repeat (8)   step(100, 0, 0, 1'b1);
    repeat (24)  step(100, 0, 0, 1'b1);
    repeat (600) step(70, 50, 5, 1'b0);
    repeat (600) step(100, 100, 0, 1'b0);
    repeat (400) step(90, 20, 3, 1'b0);
    repeat (5)   step(100, 0, 0, 1'b0);
    do_reset();
    repeat (8)   step(100, 0, 0, 1'b1);
    repeat (400) step(80, 60, 2, 1'b0);
    repeat (13)  step(100, 100, 0, 1'b0);
    do_reset();
    repeat (300) step(85, 40, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
